corevx_tlb: RTL

//  Direct-mapped Sv32-style TLB between the fetch/LSU translation port and the page-table walker.

---
 rtl/corevx_tlb_pkg.sv | 13 +
 rtl/corevx_tlb_array.sv | 39 +++
 rtl/corevx_tlb.sv | 97 +++++++++
 3 files changed

// File: rtl/corevx_tlb_pkg.sv
// corevx_tlb_pkg: shared TLB state encoding, bare-mode access bits and access-bit positions
package corevx_tlb_pkg;
  typedef enum logic [2:0] {IDLE, LOOKUP, PTW_REQ, PTW_WAIT, RESP} tlb_state_e;
  localparam logic [7:0] TLB_BARE_ACCESS_BITS = 8'hCF;
  localparam int ACCESSTAG_V = 0;
  localparam int ACCESSTAG_R = 1;
  localparam int ACCESSTAG_W = 2;
  localparam int ACCESSTAG_X = 3;
  localparam int ACCESSTAG_U = 4;
  localparam int ACCESSTAG_G = 5;
  localparam int ACCESSTAG_A = 6;
  localparam int ACCESSTAG_D = 7;
endpackage

// File: rtl/corevx_tlb_array.sv
// corevx_tlb_array: direct-mapped TLB entry storage, one write port, combinational read, flash clear
module corevx_tlb_array #(
  parameter int ENTRIES = 16,
  parameter int IDX_W = $clog2(ENTRIES),
  parameter int TAG_W = 20 - IDX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             we,
  input  logic [IDX_W-1:0] widx,
  input  logic [TAG_W-1:0] wtag,
  input  logic [21:0]      wppn,
  input  logic [7:0]       wacc,
  input  logic [IDX_W-1:0] ridx,
  output logic             rvalid,
  output logic [TAG_W-1:0] rtag,
  output logic [21:0]      rppn,
  output logic [7:0]       racc
);
  logic [ENTRIES-1:0] valid;
  logic [TAG_W-1:0] tag_q [ENTRIES];
  logic [21:0] ppn_q [ENTRIES];
  logic [7:0] acc_q [ENTRIES];
  // clear beats a same-cycle write so a flushed refill never becomes visible
  always_ff @(posedge clk)
    if (rst || clr) valid <= '0;
    else if (we) valid[widx] <= 1'b1;
  always_ff @(posedge clk)
    if (we) begin
      tag_q[widx] <= wtag;
      ppn_q[widx] <= wppn;
      acc_q[widx] <= wacc;
    end
  assign rvalid = valid[ridx];
  assign rtag = tag_q[ridx];
  assign rppn = ppn_q[ridx];
  assign racc = acc_q[ridx];
endmodule

// File: rtl/corevx_tlb.sv
// corevx_tlb: direct-mapped Sv32 TLB; hits/bare answer in two cycles, misses run one walker resolve
module corevx_tlb
  import corevx_tlb_pkg::*;
#(
  parameter int ENTRIES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [19:0] req_vaddr,
  output logic        resp_valid,
  output logic [21:0] resp_ppn,
  output logic [7:0]  resp_access_bits,
  output logic        resp_pagefault,
  output logic        resp_accessfault,
  input  logic        invalidate,
  input  logic        matp_mode,
  output logic        resolve_request,
  input  logic        resolve_ack,
  output logic [19:0] virtual_address,
  input  logic        resolve_done,
  input  logic        resolve_pagefault,
  input  logic        resolve_accessfault,
  input  logic [7:0]  resolve_access_bits,
  input  logic [21:0] resolve_physical_address
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 20 - IDX_W;
  tlb_state_e state, state_nx;
  logic [19:0] vpn_q;
  logic mode_q, drop_q;
  logic rd_valid;
  logic [TAG_W-1:0] rd_tag;
  logic [21:0] rd_ppn;
  logic [7:0] rd_acc;
  logic hit, lookup_done, walk_done, refill;
  assign req_ready = state == IDLE;
  assign resolve_request = state == PTW_REQ;
  assign virtual_address = vpn_q;
  assign hit = rd_valid && rd_tag == vpn_q[19:IDX_W];
  assign lookup_done = state == LOOKUP && (!mode_q || hit);
  assign walk_done = state == PTW_WAIT && resolve_done;
  assign refill = walk_done && !resolve_pagefault && !resolve_accessfault && !drop_q;
  corevx_tlb_array #(.ENTRIES(ENTRIES)) u_array (
    .clk(clk), .rst(rst), .clr(invalidate), .we(refill),
    .widx(vpn_q[IDX_W-1:0]), .wtag(vpn_q[19:IDX_W]),
    .wppn(resolve_physical_address), .wacc(resolve_access_bits),
    .ridx(vpn_q[IDX_W-1:0]),
    .rvalid(rd_valid), .rtag(rd_tag), .rppn(rd_ppn), .racc(rd_acc)
  );
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (req_valid) state_nx = LOOKUP;
      LOOKUP:   state_nx = (!mode_q || hit) ? IDLE : PTW_REQ;
      PTW_REQ:  if (resolve_ack) state_nx = PTW_WAIT;
      PTW_WAIT: if (resolve_done) state_nx = RESP;
      RESP:     state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end
  // a flush while a walk is in flight makes its result stale, so it is delivered but not cached
  always_ff @(posedge clk)
    if (rst) begin
      vpn_q <= '0;
      mode_q <= 1'b0;
      drop_q <= 1'b0;
      resp_valid <= 1'b0;
      resp_ppn <= '0;
      resp_access_bits <= '0;
      resp_pagefault <= 1'b0;
      resp_accessfault <= 1'b0;
    end else begin
      if (req_ready && req_valid) begin
        vpn_q <= req_vaddr;
        mode_q <= matp_mode;
      end
      drop_q <= (state == LOOKUP) ? 1'b0 : drop_q || ((state == PTW_REQ || state == PTW_WAIT) && invalidate);
      resp_valid <= lookup_done || walk_done;
      if (lookup_done) begin
        resp_ppn <= mode_q ? rd_ppn : {2'b00, vpn_q};
        resp_access_bits <= mode_q ? rd_acc : TLB_BARE_ACCESS_BITS;
        resp_pagefault <= 1'b0;
        resp_accessfault <= 1'b0;
      end
      if (walk_done) begin
        resp_ppn <= resolve_physical_address;
        resp_access_bits <= resolve_access_bits;
        resp_pagefault <= resolve_pagefault;
        resp_accessfault <= resolve_accessfault;
      end
    end
endmodule
